// File: rtl/module_display_mux.sv
// Time-multiplexed driver for a common-anode hex display: one digit per tick slot,
// a fixed blanking gap between digits, and display data captured once per frame.
module module_display_mux #(
   parameter int N_DIGITS     = 4,
   parameter int BLANK_CYCLES = 16,
   parameter int BLANK_BITS   = 5
) (
   input  logic                  clk_10Mhz_i,
   input  logic                  reset_i,
   input  logic                  tick_i,
   input  logic [4*N_DIGITS-1:0] data_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic [N_DIGITS-1:0]   enable_i,
   input  logic                  lz_blank_i,
   output logic [N_DIGITS-1:0]   anodo_o,
   output logic [6:0]            catodo_o,
   output logic                  dp_o,
   output logic                  frame_o
);

   localparam int IDX_BITS = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_BITS-1:0]   LAST_IDX  = IDX_BITS'(N_DIGITS - 1);
   localparam logic [BLANK_BITS-1:0] BLANK_END = BLANK_BITS'(BLANK_CYCLES - 1);

   typedef enum logic {
      BLANK,
      SHOW
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [IDX_BITS-1:0]   idx;
   logic [IDX_BITS-1:0]   next_idx;
   logic [BLANK_BITS-1:0] cnt;
   logic [BLANK_BITS-1:0] next_cnt;
   logic                  latch;

   logic [4*N_DIGITS-1:0] sh_data;
   logic [N_DIGITS-1:0]   sh_dp;
   logic [N_DIGITS-1:0]   sh_en;
   logic                  sh_lz;

   logic [3:0]            nib [N_DIGITS];
   logic [N_DIGITS-1:0]   suppress;
   logic                  zero_run;
   logic [3:0]            cur_nib;
   logic [6:0]            cur_seg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0:    hex7 = 7'b1000000;
         4'h1:    hex7 = 7'b1111001;
         4'h2:    hex7 = 7'b0100100;
         4'h3:    hex7 = 7'b0110000;
         4'h4:    hex7 = 7'b0011001;
         4'h5:    hex7 = 7'b0010010;
         4'h6:    hex7 = 7'b0000010;
         4'h7:    hex7 = 7'b1111000;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0010000;
         4'hA:    hex7 = 7'b0001000;
         4'hB:    hex7 = 7'b0000011;
         4'hC:    hex7 = 7'b1000110;
         4'hD:    hex7 = 7'b0100001;
         4'hE:    hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   // Scanning from the most significant digit down, a digit is blanked while every
   // nibble from it upward is zero; digit 0 always shows.
   always_comb begin
      nib      = '{default: '0};
      suppress = '0;
      zero_run = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         nib[i]      = sh_data[4*i +: 4];
         zero_run    = zero_run & (nib[i] == 4'h0);
         suppress[i] = sh_lz & zero_run & (i != 0);
      end
   end

   assign cur_nib = nib[idx];
   assign cur_seg = suppress[idx] ? 7'b1111111 : hex7(cur_nib);

   // Slot sequencing: ticks only end a SHOW slot; the blank gap runs on its own
   // counter, and wrapping back to digit 0 marks the frame boundary.
   always_comb begin
      next_state = state;
      next_idx   = idx;
      next_cnt   = cnt;
      latch      = 1'b0;
      case (state)
         BLANK: begin
            if (cnt == BLANK_END) begin
               next_cnt   = '0;
               next_state = SHOW;
               if (idx == LAST_IDX) begin
                  next_idx = '0;
                  latch    = 1'b1;
               end else begin
                  next_idx = idx + 1'b1;
               end
            end else begin
               next_cnt = cnt + 1'b1;
            end
         end
         SHOW: begin
            if (tick_i) begin
               next_state = BLANK;
            end
         end
         default: next_state = BLANK;
      endcase
   end

   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) begin
         state <= BLANK;
         idx   <= LAST_IDX;
         cnt   <= '0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         cnt   <= next_cnt;
      end
   end

   // Frame shadow: inputs may change freely; only the frame boundary samples them.
   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) begin
         sh_data <= '0;
         sh_dp   <= '0;
         sh_en   <= '0;
         sh_lz   <= 1'b0;
      end else if (latch) begin
         sh_data <= data_i;
         sh_dp   <= dp_i;
         sh_en   <= enable_i;
         sh_lz   <= lz_blank_i;
      end
   end

   // Pin drivers follow the state one cycle later on both edges of a slot, so the
   // dark gap seen on the pins is exactly BLANK_CYCLES long.
   always_ff @(posedge clk_10Mhz_i or posedge reset_i) begin
      if (reset_i) begin
         anodo_o  <= '1;
         catodo_o <= 7'b1111111;
         dp_o     <= 1'b1;
         frame_o  <= 1'b0;
      end else begin
         frame_o <= latch;
         if (state == SHOW) begin
            anodo_o  <= sh_en[idx] ? ~(N_DIGITS'(1) << idx) : '1;
            catodo_o <= cur_seg;
            dp_o     <= ~sh_dp[idx];
         end else begin
            anodo_o  <= '1;
            catodo_o <= 7'b1111111;
            dp_o     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_module_display_mux.sv
// Bench for module_display_mux: directed scan scenarios plus a randomized run, all
// checked cycle by cycle against a slot-level behavioural model of the display.
module tb_module_display_mux;

   localparam int N  = 4;
   localparam int BC = 4;

   logic         clock;
   logic         reset;
   logic         tick;
   logic [15:0]  data;
   logic [3:0]   dp_req;
   logic [3:0]   enable;
   logic         lz_blank;
   logic [3:0]   anodo;
   logic [6:0]   catodo;
   logic         dp_out;
   logic         frame;

   int n_compared;
   int n_mismatched;

   // Model of what the display is doing: showing or in a gap, which digit, and the
   // frame snapshot that is currently visible.
   bit           m_show;
   int           m_digit;
   int           m_gap;
   logic [15:0]  m_val;
   logic [3:0]   m_dp;
   logic [3:0]   m_en;
   logic         m_lz;

   int mon_frames, mon_f, mon_e, mon_d, mon_b, mon_7, mon_dp_on, mon_dp_bad;

   logic [6:0] seg_lut [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   module_display_mux #(
      .N_DIGITS(N),
      .BLANK_CYCLES(BC),
      .BLANK_BITS(3)
   ) dut (
      .clk_10Mhz_i(clock),
      .reset_i(reset),
      .tick_i(tick),
      .data_i(data),
      .dp_i(dp_req),
      .enable_i(enable),
      .lz_blank_i(lz_blank),
      .anodo_o(anodo),
      .catodo_o(catodo),
      .dp_o(dp_out),
      .frame_o(frame)
   );

   initial clock = 1'b0;
   always #50 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic t, input logic [15:0] d, input logic [3:0] p,
                                 input logic [3:0] e, input logic z);
      tick     = t;
      data     = d;
      dp_req   = p;
      enable   = e;
      lz_blank = z;
   endtask

   task automatic model_reset();
      m_show  = 1'b0;
      m_digit = N - 1;
      m_gap   = 0;
      m_val   = '0;
      m_dp    = '0;
      m_en    = '0;
      m_lz    = 1'b0;
   endtask

   task automatic model_expect(output logic [3:0] ea, output logic [6:0] ec,
                               output logic ed, output logic ef);
      logic [15:0] upper;
      ea = 4'hF;
      ec = 7'h7F;
      ed = 1'b1;
      ef = 1'b0;
      if (!reset) begin
         if (m_show) begin
            upper = m_val >> (4 * m_digit);
            if (m_en[m_digit]) ea = 4'hF & ~(4'b0001 << m_digit);
            ec = (m_lz && m_digit > 0 && upper == 16'h0) ? 7'h7F : seg_lut[upper[3:0]];
            ed = ~m_dp[m_digit];
         end
         ef = (!m_show && m_gap == BC - 1 && m_digit == N - 1);
      end
   endtask

   task automatic model_advance();
      if (m_show) begin
         if (tick) begin
            m_show = 1'b0;
            m_gap  = 0;
         end
      end else if (m_gap == BC - 1) begin
         m_gap   = 0;
         m_show  = 1'b1;
         m_digit = (m_digit + 1) % N;
         if (m_digit == 0) begin
            m_val = data;
            m_dp  = dp_req;
            m_en  = enable;
            m_lz  = lz_blank;
         end
      end else begin
         m_gap++;
      end
   endtask

   task automatic clear_monitors();
      mon_frames = 0; mon_f = 0; mon_e = 0; mon_d = 0;
      mon_b = 0; mon_7 = 0; mon_dp_on = 0; mon_dp_bad = 0;
   endtask

   // One clock: predict, clock the DUT, then compare #1 after the edge.
   task automatic run_cycle();
      logic [3:0] ea;
      logic [6:0] ec;
      logic       ed, ef;
      model_expect(ea, ec, ed, ef);
      if (reset) model_reset();
      else       model_advance();
      @(posedge clock);
      #1;
      check_output("anodo", 32'(anodo), 32'(ea));
      check_output("catodo", 32'(catodo), 32'(ec));
      check_output("dp", 32'(dp_out), 32'(ed));
      check_output("frame", 32'(frame), 32'(ef));
      if (frame) mon_frames++;
      case (anodo)
         4'b1111: mon_f++;
         4'b1110: mon_e++;
         4'b1101: mon_d++;
         4'b1011: mon_b++;
         4'b0111: mon_7++;
         default: ;
      endcase
      if (!dp_out) begin
         mon_dp_on++;
         if (anodo != 4'b1110) mon_dp_bad++;
      end
   endtask

   // Ends the current slot and runs until the next anode lights; reports the dark gap.
   task automatic advance(output int blanks);
      int n;
      tick = 1'b1;
      run_cycle();
      tick = 1'b0;
      n = 0;
      blanks = 0;
      do begin
         run_cycle();
         n++;
         if (anodo == 4'hF) blanks++;
      end while (anodo == 4'hF && n < 40);
      check_output("slot_budget", 32'(n < 40), 32'd1);
   endtask

   task automatic slot_fixed();
      tick = 1'b1;
      run_cycle();
      tick = 1'b0;
      repeat (19) run_cycle();
   endtask

   logic [3:0] exp_an  [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
   logic [6:0] exp_seg [4] = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b0011001};

   initial begin
      int blanks;
      n_compared   = 0;
      n_mismatched = 0;
      clear_monitors();
      reset = 1'b1;
      apply_stimulus(1'b0, 16'h1234, 4'h0, 4'hF, 1'b0);
      model_reset();

      // Reset state, then first frame appears without any tick.
      repeat (3) run_cycle();
      reset = 1'b0;
      clear_monitors();
      repeat (5) run_cycle();
      check_output("t1_frames", 32'(mon_frames), 32'd1);
      check_output("t1_anodo", 32'(anodo), 32'(4'b1110));
      check_output("t1_catodo", 32'(catodo), 32'(7'b0011001));
      repeat (30) run_cycle();
      check_output("t1_hold", 32'(anodo), 32'(4'b1110));

      $display("[TB] scan sequence with periodic ticks");
      for (int s = 0; s < 4; s++) begin
         repeat (15) run_cycle();
         clear_monitors();
         advance(blanks);
         check_output("t2_gap", 32'(blanks), 32'(BC));
         check_output("t2_anodo", 32'(anodo), 32'(exp_an[s]));
         check_output("t2_catodo", 32'(catodo), 32'(exp_seg[s]));
         check_output("t2_frames", 32'(mon_frames), (s == 3) ? 32'd1 : 32'd0);
      end

      $display("[TB] mid-frame data change");
      advance(blanks);
      advance(blanks);
      check_output("t3_d2", 32'(catodo), 32'(7'b0100100));
      data = 16'hABCD;
      advance(blanks);
      check_output("t3_d3_an", 32'(anodo), 32'(4'b0111));
      check_output("t3_d3", 32'(catodo), 32'(7'b1111001));
      advance(blanks);
      check_output("t3_d0_an", 32'(anodo), 32'(4'b1110));
      check_output("t3_d0", 32'(catodo), 32'(7'b0100001));

      $display("[TB] leading-zero suppression");
      apply_stimulus(1'b0, 16'h0070, 4'h0, 4'hF, 1'b1);
      repeat (4) advance(blanks);
      check_output("t4_d0", 32'(catodo), 32'(7'b1000000));
      advance(blanks);
      check_output("t4_d1", 32'(catodo), 32'(7'b1111000));
      advance(blanks);
      check_output("t4_d2_an", 32'(anodo), 32'(4'b1011));
      check_output("t4_d2", 32'(catodo), 32'(7'b1111111));
      advance(blanks);
      check_output("t4_d3_an", 32'(anodo), 32'(4'b0111));
      check_output("t4_d3", 32'(catodo), 32'(7'b1111111));
      advance(blanks);

      $display("[TB] per-digit enable and decimal point");
      apply_stimulus(1'b0, 16'h1234, 4'b0001, 4'b0101, 1'b0);
      repeat (4) slot_fixed();
      clear_monitors();
      repeat (4) slot_fixed();
      check_output("t5_dark", 32'(mon_f), 32'd48);
      check_output("t5_d0", 32'(mon_e), 32'd16);
      check_output("t5_d2", 32'(mon_b), 32'd16);
      check_output("t5_d1", 32'(mon_d), 32'd0);
      check_output("t5_d3", 32'(mon_7), 32'd0);
      check_output("t5_dp_on", 32'(mon_dp_on), 32'd16);
      check_output("t5_dp_bad", 32'(mon_dp_bad), 32'd0);

      $display("[TB] asynchronous reset mid-show");
      @(negedge clock);
      #7 reset = 1'b1;
      #2;
      check_output("t6_anodo", 32'(anodo), 32'(4'hF));
      check_output("t6_catodo", 32'(catodo), 32'(7'h7F));
      model_reset();
      apply_stimulus(1'b0, 16'h1234, 4'h0, 4'hF, 1'b0);
      repeat (2) run_cycle();
      reset = 1'b0;
      clear_monitors();
      repeat (5) run_cycle();
      check_output("t6_frames", 32'(mon_frames), 32'd1);
      check_output("t6_restart_an", 32'(anodo), 32'(4'b1110));
      check_output("t6_restart", 32'(catodo), 32'(7'b0011001));

      $display("[TB] randomized run");
      for (int c = 0; c < 1500; c++) begin
         tick     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) data = 16'($urandom);
         if ($urandom_range(0, 31) == 0) begin
            dp_req   = 4'($urandom);
            enable   = 4'($urandom);
            lz_blank = 1'($urandom);
         end
         run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
